// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage - data-bus load/store, load align/extend,
//             WB handoff, MEM->EX forwarding and load-busy hazard flag.
// Rev 1.0
// ============================================================================
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_flush_i,
  input  logic            EX_valid_i,
  output logic            MEM_ready_o,
  input  logic [XLEN-1:0] EX_pc_i,
  input  logic [XLEN-1:0] EX_alu_res_i,
  input  logic [XLEN-1:0] EX_rs2_rdata_i,
  input  logic            EX_load_i,
  input  logic            EX_store_i,
  input  logic [1:0]      EX_size_i,
  input  logic            EX_unsigned_i,
  input  logic            EX_rd_wen_i,
  input  logic [4:0]      EX_rd_idx_i,
  output logic            dbus_req_valid_o,
  input  logic            dbus_req_ready_i,
  output logic [XLEN-1:0] dbus_req_addr_o,
  output logic            dbus_req_wen_o,
  output logic [XLEN-1:0] dbus_req_wdata_o,
  output logic [3:0]      dbus_req_wmask_o,
  input  logic            dbus_rsp_valid_i,
  input  logic [XLEN-1:0] dbus_rsp_rdata_i,
  input  logic            dbus_rsp_err_i,
  output logic            MEM_valid_o,
  input  logic            WB_ready_i,
  output logic [XLEN-1:0] MEM_pc_o,
  output logic            MEM_rd_wen_o,
  output logic [4:0]      MEM_rd_idx_o,
  output logic [XLEN-1:0] MEM_fwd_data_o,
  output logic            MEM_load_busy_o,
  output logic            MEM_misalign_o,
  output logic            MEM_bus_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RSP   = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            data_valid_q, data_valid_d;
  logic [XLEN-1:0] pc_q, addr_q, sdata_q, rdata_q;
  logic            load_q, store_q, unsigned_q, rd_wen_q, err_q;
  logic [1:0]      size_q;
  logic [4:0]      rd_idx_q;

  logic            w_capture, w_ex_misalign, w_go_req, w_rsp_take;
  logic            w_misalign, w_in_slot, w_in_req, w_in_done;
  logic [XLEN-1:0] w_lane, w_load_data, w_wdata;
  logic [3:0]      w_wmask;

  // Half needs addr[0]==0; word (and the illegal size 3) needs addr[1:0]==0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    misaligned = ((size == 2'd1) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  assign w_in_req   = (state_q == S_REQ);
  assign w_in_done  = (state_q == S_DONE);
  assign w_in_slot  = data_valid_q && ((state_q == S_IDLE) || w_in_done);

  assign MEM_valid_o = w_in_slot;
  assign MEM_ready_o = ((state_q == S_IDLE) || w_in_done) &&
                       (!data_valid_q || (MEM_valid_o && WB_ready_i));

  assign w_capture     = MEM_ready_o && EX_valid_i && !mem_flush_i;
  assign w_ex_misalign = misaligned(EX_size_i, EX_alu_res_i[1:0]);
  assign w_go_req      = w_capture && (EX_load_i || EX_store_i) && !w_ex_misalign;
  assign w_rsp_take    = (state_q == S_RSP) && dbus_rsp_valid_i && !mem_flush_i;

  always_comb begin
    data_valid_d = data_valid_q;
    if (mem_flush_i)      data_valid_d = 1'b0;
    else if (MEM_ready_o) data_valid_d = EX_valid_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_go_req) state_d = S_REQ;
      end
      S_REQ: begin
        // A flush in the accept cycle still leaves a response in flight.
        if (dbus_req_ready_i) state_d = mem_flush_i ? S_DRAIN : S_RSP;
        else if (mem_flush_i) state_d = S_IDLE;
      end
      S_RSP: begin
        if (dbus_rsp_valid_i) state_d = mem_flush_i ? S_IDLE : S_DONE;
        else if (mem_flush_i) state_d = S_DRAIN;
      end
      S_DONE: begin
        if (mem_flush_i)     state_d = S_IDLE;
        else if (WB_ready_i) state_d = w_go_req ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (dbus_rsp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      data_valid_q <= 1'b0;
      pc_q         <= '0;
      addr_q       <= '0;
      sdata_q      <= '0;
      rdata_q      <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      rd_wen_q     <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= 2'd0;
      rd_idx_q     <= 5'd0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
      if (w_capture) begin
        pc_q       <= EX_pc_i;
        addr_q     <= EX_alu_res_i;
        sdata_q    <= EX_rs2_rdata_i;
        load_q     <= EX_load_i;
        store_q    <= EX_store_i;
        unsigned_q <= EX_unsigned_i;
        rd_wen_q   <= EX_rd_wen_i;
        size_q     <= EX_size_i;
        rd_idx_q   <= EX_rd_idx_i;
        err_q      <= 1'b0;
      end
      if (w_rsp_take) begin
        rdata_q <= dbus_rsp_rdata_i;
        err_q   <= dbus_rsp_err_i;
      end
    end
  end

  assign w_misalign = (load_q || store_q) && misaligned(size_q, addr_q[1:0]);
  assign w_lane     = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    w_load_data = w_lane;
    w_wdata     = sdata_q;
    w_wmask     = 4'b1111;
    case (size_q)
      2'd0: begin
        w_load_data = {{(XLEN-8){!unsigned_q && w_lane[7]}}, w_lane[7:0]};
        w_wdata     = {4{sdata_q[7:0]}};
        w_wmask     = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        w_load_data = {{(XLEN-16){!unsigned_q && w_lane[15]}}, w_lane[15:0]};
        w_wdata     = {2{sdata_q[15:0]}};
        w_wmask     = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_load_data = w_lane;
        w_wdata     = sdata_q;
        w_wmask     = 4'b1111;
      end
    endcase
  end

  assign dbus_req_valid_o = w_in_req;
  assign dbus_req_addr_o  = w_in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dbus_req_wen_o   = w_in_req && store_q;
  assign dbus_req_wdata_o = (w_in_req && store_q) ? w_wdata : '0;
  assign dbus_req_wmask_o = (w_in_req && store_q) ? w_wmask : 4'b0000;

  assign MEM_pc_o        = data_valid_q ? pc_q : '0;
  assign MEM_rd_idx_o    = data_valid_q ? rd_idx_q : 5'd0;
  assign MEM_misalign_o  = data_valid_q && w_misalign;
  assign MEM_bus_err_o   = data_valid_q && w_in_done && err_q;
  assign MEM_load_busy_o = data_valid_q && load_q && !w_misalign && !w_in_done;
  // Loads only forward once their data has arrived cleanly.
  assign MEM_rd_wen_o    = w_in_slot && rd_wen_q && !store_q && !w_misalign &&
                           (!load_q || (w_in_done && !err_q));

  always_comb begin
    MEM_fwd_data_o = '0;
    if (data_valid_q) begin
      if (!load_q)                    MEM_fwd_data_o = addr_q;
      else if (w_in_done && !err_q)   MEM_fwd_data_o = w_load_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Testbench for mem_stage: directed scenarios plus randomized ops checked against a byte-lane model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush_i, EX_valid_i, MEM_ready_o;
  logic [31:0] EX_pc_i, EX_alu_res_i, EX_rs2_rdata_i;
  logic        EX_load_i, EX_store_i, EX_unsigned_i, EX_rd_wen_i;
  logic [1:0]  EX_size_i;
  logic [4:0]  EX_rd_idx_i;
  logic        dbus_req_valid_o, dbus_req_ready_i, dbus_req_wen_o;
  logic [31:0] dbus_req_addr_o, dbus_req_wdata_o;
  logic [3:0]  dbus_req_wmask_o;
  logic        dbus_rsp_valid_i, dbus_rsp_err_i;
  logic [31:0] dbus_rsp_rdata_i;
  logic        MEM_valid_o, WB_ready_i, MEM_rd_wen_o;
  logic [31:0] MEM_pc_o, MEM_fwd_data_o;
  logic [4:0]  MEM_rd_idx_o;
  logic        MEM_load_busy_o, MEM_misalign_o, MEM_bus_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .mem_flush_i(mem_flush_i),
    .EX_valid_i(EX_valid_i), .MEM_ready_o(MEM_ready_o),
    .EX_pc_i(EX_pc_i), .EX_alu_res_i(EX_alu_res_i), .EX_rs2_rdata_i(EX_rs2_rdata_i),
    .EX_load_i(EX_load_i), .EX_store_i(EX_store_i), .EX_size_i(EX_size_i),
    .EX_unsigned_i(EX_unsigned_i), .EX_rd_wen_i(EX_rd_wen_i), .EX_rd_idx_i(EX_rd_idx_i),
    .dbus_req_valid_o(dbus_req_valid_o), .dbus_req_ready_i(dbus_req_ready_i),
    .dbus_req_addr_o(dbus_req_addr_o), .dbus_req_wen_o(dbus_req_wen_o),
    .dbus_req_wdata_o(dbus_req_wdata_o), .dbus_req_wmask_o(dbus_req_wmask_o),
    .dbus_rsp_valid_i(dbus_rsp_valid_i), .dbus_rsp_rdata_i(dbus_rsp_rdata_i),
    .dbus_rsp_err_i(dbus_rsp_err_i),
    .MEM_valid_o(MEM_valid_o), .WB_ready_i(WB_ready_i), .MEM_pc_o(MEM_pc_o),
    .MEM_rd_wen_o(MEM_rd_wen_o), .MEM_rd_idx_o(MEM_rd_idx_o), .MEM_fwd_data_o(MEM_fwd_data_o),
    .MEM_load_busy_o(MEM_load_busy_o), .MEM_misalign_o(MEM_misalign_o), .MEM_bus_err_o(MEM_bus_err_o)
  );

  // Reference: gather n bytes starting at byte lane b, then extend from the top byte.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int b, input int n, input logic uns);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (((w >> (8 * (b + i))) & 32'hFF) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) v[8 * i +: 8] = 8'((d >> (8 * (i % n))) & 32'hFF);
    return v;
  endfunction

  function automatic logic [3:0] ref_wmask(input int b, input int n);
    logic [3:0] m = 4'b0000;
    for (int i = 0; i < 4; i++) m[i] = (i >= b) && (i < b + n);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_flush_i = 0; EX_valid_i = 0; EX_pc_i = 0; EX_alu_res_i = 0; EX_rs2_rdata_i = 0;
    EX_load_i = 0; EX_store_i = 0; EX_size_i = 0; EX_unsigned_i = 0; EX_rd_wen_i = 0;
    EX_rd_idx_i = 0; dbus_req_ready_i = 0; dbus_rsp_valid_i = 0; dbus_rsp_rdata_i = 0;
    dbus_rsp_err_i = 0; WB_ready_i = 0;
  endtask

  // Presents one instruction and returns one cycle after the capture edge.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic rdw, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [31:0] pc);
    EX_load_i = ld; EX_store_i = st; EX_size_i = sz; EX_unsigned_i = uns; EX_rd_wen_i = rdw;
    EX_rd_idx_i = rd; EX_alu_res_i = alu; EX_rs2_rdata_i = rs2; EX_pc_i = pc; EX_valid_i = 1;
    for (int i = 0; i < 20 && !MEM_ready_o; i++) step();
    checks++; if (MEM_ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready_timeout got=%b exp=1", MEM_ready_o); end
    step();
    EX_valid_i = 0;
  endtask

  task automatic release_wb();
    WB_ready_i = 1;
    step();
    WB_ready_i = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (MEM_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", MEM_valid_o); end
    checks++; if (dbus_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dbus_req_valid_o); end
    checks++; if (MEM_fwd_data_o !== 32'h0) begin errors++; $display("FAIL rst_fwd got=%h exp=0", MEM_fwd_data_o); end
    checks++; if ({MEM_rd_wen_o, MEM_load_busy_o, MEM_misalign_o, MEM_bus_err_o} !== 4'b0) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {MEM_rd_wen_o, MEM_load_busy_o, MEM_misalign_o, MEM_bus_err_o}); end
    rst = 1;
    step();
    checks++; if (MEM_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", MEM_ready_o); end
  endtask

  task automatic test_alu();
    issue(0, 0, 2'd2, 0, 1, 5'd5, 32'h1234, 32'h0, 32'h1000);
    checks++; if (MEM_valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b exp=1", MEM_valid_o); end
    checks++; if (MEM_rd_wen_o !== 1'b1) begin errors++; $display("FAIL alu_rdwen got=%b exp=1", MEM_rd_wen_o); end
    checks++; if (MEM_rd_idx_o !== 5'd5) begin errors++; $display("FAIL alu_idx got=%0d exp=5", MEM_rd_idx_o); end
    checks++; if (MEM_fwd_data_o !== 32'h1234) begin errors++; $display("FAIL alu_fwd got=%h exp=00001234", MEM_fwd_data_o); end
    checks++; if (MEM_pc_o !== 32'h1000) begin errors++; $display("FAIL alu_pc got=%h exp=00001000", MEM_pc_o); end
    checks++; if (MEM_ready_o !== 1'b0) begin errors++; $display("FAIL alu_ready_stall got=%b exp=0", MEM_ready_o); end
    checks++; if (dbus_req_valid_o !== 1'b0) begin errors++; $display("FAIL alu_noreq got=%b exp=0", dbus_req_valid_o); end
    WB_ready_i = 1;
    #1;
    checks++; if (MEM_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready_wb got=%b exp=1", MEM_ready_o); end
    step();
    WB_ready_i = 0;
    checks++; if (MEM_valid_o !== 1'b0) begin errors++; $display("FAIL alu_freed got=%b exp=0", MEM_valid_o); end
  endtask

  task automatic test_load_byte();
    issue(1, 0, 2'd0, 0, 1, 5'd9, 32'h103, 32'h0, 32'h1004);
    checks++; if (dbus_req_valid_o !== 1'b1) begin errors++; $display("FAIL lb_req got=%b exp=1", dbus_req_valid_o); end
    checks++; if (dbus_req_addr_o !== 32'h100) begin errors++; $display("FAIL lb_addr got=%h exp=00000100", dbus_req_addr_o); end
    checks++; if ({dbus_req_wen_o, dbus_req_wmask_o} !== 5'b0) begin errors++; $display("FAIL lb_wen_mask got=%b exp=00000", {dbus_req_wen_o, dbus_req_wmask_o}); end
    checks++; if (MEM_load_busy_o !== 1'b1) begin errors++; $display("FAIL lb_busy got=%b exp=1", MEM_load_busy_o); end
    checks++; if (MEM_rd_wen_o !== 1'b0) begin errors++; $display("FAIL lb_rdwen_early got=%b exp=0", MEM_rd_wen_o); end
    dbus_req_ready_i = 1;
    step();
    dbus_req_ready_i = 0;
    checks++; if ({dbus_req_valid_o, MEM_valid_o} !== 2'b00) begin errors++; $display("FAIL lb_t2 got=%b exp=00", {dbus_req_valid_o, MEM_valid_o}); end
    dbus_rsp_valid_i = 1; dbus_rsp_rdata_i = 32'h80AA_BBCC;
    step();
    dbus_rsp_valid_i = 0; dbus_rsp_rdata_i = 32'h0;
    checks++; if (MEM_valid_o !== 1'b1) begin errors++; $display("FAIL lb_valid_t3 got=%b exp=1", MEM_valid_o); end
    checks++; if (MEM_fwd_data_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", MEM_fwd_data_o); end
    checks++; if ({MEM_rd_wen_o, MEM_load_busy_o} !== 2'b10) begin errors++; $display("FAIL lb_wen_busy got=%b exp=10", {MEM_rd_wen_o, MEM_load_busy_o}); end
    release_wb();
    checks++; if (MEM_valid_o !== 1'b0) begin errors++; $display("FAIL lb_freed got=%b exp=0", MEM_valid_o); end
  endtask

  task automatic test_store_half();
    issue(0, 1, 2'd1, 0, 1, 5'd3, 32'h102, 32'h1234_BEEF, 32'h1008);
    for (int i = 0; i < 4; i++) begin
      checks++; if (dbus_req_valid_o !== 1'b1) begin errors++; $display("FAIL sh_req[%0d] got=%b exp=1", i, dbus_req_valid_o); end
      checks++; if ({dbus_req_addr_o, dbus_req_wdata_o} !== {32'h100, 32'hBEEF_BEEF}) begin errors++; $display("FAIL sh_addr_data[%0d] got=%h/%h exp=00000100/beefbeef", i, dbus_req_addr_o, dbus_req_wdata_o); end
      checks++; if ({dbus_req_wen_o, dbus_req_wmask_o} !== 5'b1_1100) begin errors++; $display("FAIL sh_wen_mask[%0d] got=%b exp=11100", i, {dbus_req_wen_o, dbus_req_wmask_o}); end
      if (i == 3) dbus_req_ready_i = 1;
      step();
    end
    dbus_req_ready_i = 0;
    dbus_rsp_valid_i = 1;
    step();
    dbus_rsp_valid_i = 0;
    checks++; if ({MEM_valid_o, MEM_rd_wen_o} !== 2'b10) begin errors++; $display("FAIL sh_done got=%b exp=10", {MEM_valid_o, MEM_rd_wen_o}); end
    release_wb();
  endtask

  task automatic test_misalign();
    issue(1, 0, 2'd2, 0, 1, 5'd4, 32'h101, 32'h0, 32'h100C);
    checks++; if (dbus_req_valid_o !== 1'b0) begin errors++; $display("FAIL mis_noreq got=%b exp=0", dbus_req_valid_o); end
    checks++; if ({MEM_valid_o, MEM_misalign_o} !== 2'b11) begin errors++; $display("FAIL mis_valid_flag got=%b exp=11", {MEM_valid_o, MEM_misalign_o}); end
    checks++; if ({MEM_rd_wen_o, MEM_load_busy_o} !== 2'b00) begin errors++; $display("FAIL mis_wen_busy got=%b exp=00", {MEM_rd_wen_o, MEM_load_busy_o}); end
    release_wb();
    checks++; if (MEM_misalign_o !== 1'b0) begin errors++; $display("FAIL mis_cleared got=%b exp=0", MEM_misalign_o); end
  endtask

  task automatic test_flush();
    // Flush while request still pending: request dropped, stage free.
    issue(1, 0, 2'd2, 0, 1, 5'd6, 32'h180, 32'h0, 32'h1010);
    mem_flush_i = 1;
    step();
    mem_flush_i = 0;
    checks++; if ({dbus_req_valid_o, MEM_ready_o} !== 2'b01) begin errors++; $display("FAIL flush_req got=%b exp=01", {dbus_req_valid_o, MEM_ready_o}); end
    // Flush with response outstanding: drain swallows it.
    issue(1, 0, 2'd2, 0, 1, 5'd6, 32'h200, 32'h0, 32'h1014);
    dbus_req_ready_i = 1;
    step();
    dbus_req_ready_i = 0;
    mem_flush_i = 1;
    step();
    mem_flush_i = 0;
    checks++; if ({MEM_ready_o, MEM_valid_o, dbus_req_valid_o} !== 3'b000) begin errors++; $display("FAIL drain1 got=%b exp=000", {MEM_ready_o, MEM_valid_o, dbus_req_valid_o}); end
    step();
    checks++; if ({MEM_ready_o, MEM_valid_o} !== 2'b00) begin errors++; $display("FAIL drain2 got=%b exp=00", {MEM_ready_o, MEM_valid_o}); end
    dbus_rsp_valid_i = 1; dbus_rsp_rdata_i = 32'hDEAD_BEEF;
    step();
    dbus_rsp_valid_i = 0;
    checks++; if ({MEM_ready_o, MEM_valid_o} !== 2'b10) begin errors++; $display("FAIL drain_idle got=%b exp=10", {MEM_ready_o, MEM_valid_o}); end
    step();
    checks++; if (MEM_valid_o !== 1'b0) begin errors++; $display("FAIL drain_novalid got=%b exp=0", MEM_valid_o); end
  endtask

  task automatic test_bus_err();
    issue(1, 0, 2'd2, 0, 1, 5'd7, 32'h300, 32'h0, 32'h1018);
    dbus_req_ready_i = 1;
    step();
    dbus_req_ready_i = 0;
    dbus_rsp_valid_i = 1; dbus_rsp_err_i = 1; dbus_rsp_rdata_i = 32'h5555_5555;
    step();
    dbus_rsp_valid_i = 0; dbus_rsp_err_i = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({MEM_valid_o, MEM_bus_err_o, MEM_rd_wen_o} !== 3'b110) begin errors++; $display("FAIL err_flags[%0d] got=%b exp=110", i, {MEM_valid_o, MEM_bus_err_o, MEM_rd_wen_o}); end
      checks++; if ({MEM_ready_o, MEM_pc_o} !== {1'b0, 32'h1018}) begin errors++; $display("FAIL err_hold[%0d] got=%b/%h exp=0/00001018", i, MEM_ready_o, MEM_pc_o); end
      if (i < 2) step();
    end
    release_wb();
    checks++; if ({MEM_valid_o, MEM_bus_err_o} !== 2'b00) begin errors++; $display("FAIL err_freed got=%b exp=00", {MEM_valid_o, MEM_bus_err_o}); end
  endtask

  task automatic test_reset_mid();
    issue(0, 1, 2'd2, 0, 0, 5'd0, 32'h40, 32'hCAFE_F00D, 32'h101C);
    rst = 0;
    #1;
    checks++; if ({dbus_req_valid_o, MEM_load_busy_o} !== 2'b00) begin errors++; $display("FAIL rstmid_req got=%b exp=00", {dbus_req_valid_o, MEM_load_busy_o}); end
    step();
    rst = 1;
    step();
    checks++; if ({dbus_req_valid_o, MEM_ready_o} !== 2'b01) begin errors++; $display("FAIL rstmid_idle got=%b exp=01", {dbus_req_valid_o, MEM_ready_o}); end
    dbus_rsp_valid_i = 1;
    step();
    dbus_rsp_valid_i = 0;
    checks++; if (MEM_valid_o !== 1'b0) begin errors++; $display("FAIL stray_rsp got=%b exp=0", MEM_valid_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int kind = int'($urandom_range(0, 2));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom;
      logic [31:0] rs2 = $urandom;
      logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
      logic [31:0] rdata;
      logic uns = 1'($urandom_range(0, 1));
      logic rdw = 1'($urandom_range(0, 1));
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic err;
      logic ld = (kind == 1);
      logic st = (kind == 2);
      int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      int b = int'(addr % 4);
      logic mis = (ld || st) && ((addr % nb) != 0);
      int d = int'($urandom_range(0, 3));
      int r = int'($urandom_range(0, 2));
      issue(ld, st, sz, uns, rdw, rd, addr, rs2, pc);
      if (!(ld || st) || mis) begin
        checks++; if ({MEM_valid_o, dbus_req_valid_o, MEM_misalign_o} !== {1'b1, 1'b0, mis}) begin errors++; $display("FAIL rnd%0d_imm got=%b exp=%b", n, {MEM_valid_o, dbus_req_valid_o, MEM_misalign_o}, {1'b1, 1'b0, mis}); end
        checks++; if (MEM_rd_wen_o !== (rdw && !(ld || st))) begin errors++; $display("FAIL rnd%0d_rdwen got=%b exp=%b", n, MEM_rd_wen_o, rdw && !(ld || st)); end
        checks++; if ((ld || st) ? (MEM_pc_o !== pc) : ({MEM_fwd_data_o, MEM_pc_o} !== {addr, pc})) begin errors++; $display("FAIL rnd%0d_data got=%h/%h exp=%h/%h", n, MEM_fwd_data_o, MEM_pc_o, addr, pc); end
      end else begin
        for (int c = 0; c <= d; c++) begin
          checks++; if ({dbus_req_valid_o, dbus_req_wen_o, dbus_req_addr_o} !== {1'b1, st, addr & 32'hFFFF_FFFC}) begin errors++; $display("FAIL rnd%0d_req got=%b%b/%h exp=1%b/%h", n, dbus_req_valid_o, dbus_req_wen_o, dbus_req_addr_o, st, addr & 32'hFFFF_FFFC); end
          checks++; if (dbus_req_wmask_o !== (st ? ref_wmask(b, nb) : 4'b0000)) begin errors++; $display("FAIL rnd%0d_mask got=%b exp=%b", n, dbus_req_wmask_o, st ? ref_wmask(b, nb) : 4'b0000); end
          if (st) begin
            checks++; if (dbus_req_wdata_o !== ref_wdata(rs2, nb)) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", n, dbus_req_wdata_o, ref_wdata(rs2, nb)); end
          end
          if (c == d) dbus_req_ready_i = 1;
          step();
        end
        dbus_req_ready_i = 0;
        for (int c = 0; c < r; c++) begin
          checks++; if ({MEM_valid_o, MEM_load_busy_o} !== {1'b0, ld}) begin errors++; $display("FAIL rnd%0d_wait got=%b exp=0%b", n, {MEM_valid_o, MEM_load_busy_o}, ld); end
          step();
        end
        rdata = $urandom;
        err = ($urandom_range(0, 7) == 0);
        dbus_rsp_valid_i = 1; dbus_rsp_rdata_i = rdata; dbus_rsp_err_i = err;
        step();
        dbus_rsp_valid_i = 0; dbus_rsp_err_i = 0;
        checks++; if ({MEM_valid_o, MEM_bus_err_o, MEM_load_busy_o} !== {1'b1, err, 1'b0}) begin errors++; $display("FAIL rnd%0d_done got=%b exp=1%b0", n, {MEM_valid_o, MEM_bus_err_o, MEM_load_busy_o}, err); end
        checks++; if (MEM_rd_wen_o !== (ld && rdw && !err)) begin errors++; $display("FAIL rnd%0d_rdwen got=%b exp=%b", n, MEM_rd_wen_o, ld && rdw && !err); end
        if (ld && !err) begin
          checks++; if (MEM_fwd_data_o !== ref_load(rdata, b, nb, uns)) begin errors++; $display("FAIL rnd%0d_load got=%h exp=%h", n, MEM_fwd_data_o, ref_load(rdata, b, nb, uns)); end
        end
      end
      release_wb();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_flush();
    test_bus_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
